// File: rtl/psg_noise_write_controller_if.sv
// psg_noise_write_controller_if: host byte-write port with ready/drop handshake
interface psg_noise_write_controller_if;
  logic       wr;
  logic [7:0] data;
  logic       ready;
  logic       write_dropped;
  modport master (output wr, data, input ready, write_dropped);
  modport slave (input wr, data, output ready, write_dropped);
endinterface

// File: rtl/psg_noise_write_controller.sv
// psg_noise_write_controller: SN76489 noise-channel register write sequencer with busy window
module psg_noise_write_controller #(
  parameter int WRITE_CYCLES    = 32,
  parameter int COUNTER_BITS    = 10,
  parameter bit RESTART_ON_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_lfsr,
  psg_noise_write_controller_if.slave bus,
  output logic [2:0]                 noise_control,
  output logic [3:0]                 noise_atten,
  output logic [COUNTER_BITS-1:0]    tone2_freq,
  output logic                       restart_noise
);
  localparam int CW = WRITE_CYCLES > 0 ? $clog2(WRITE_CYCLES + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic [2:0]      latch_idx, idx;
  logic            accept, latch;
  assign accept    = bus.wr && bus.ready;
  assign latch     = bus.data[7];
  assign idx       = latch ? bus.data[6:4] : latch_idx;
  assign bus.ready = state == IDLE;
  // busy-window state and countdown registers
  always_ff @(posedge clk or posedge reset_lfsr)
    if (reset_lfsr) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  // load the window on acceptance, count down while busy
  always_comb begin
    state_n = state;
    count_n = count;
    if (accept && WRITE_CYCLES > 0) begin
      state_n = BUSY;
      count_n = CW'(WRITE_CYCLES);
    end else if (state == BUSY) begin
      count_n = count - 1'b1;
      state_n = count == CW'(1) ? IDLE : BUSY;
    end
  end
  // register file updates, drop pulse and LFSR restart strobe
  always_ff @(posedge clk or posedge reset_lfsr)
    if (reset_lfsr) begin
      bus.write_dropped <= 1'b0;
      restart_noise     <= 1'b0;
      latch_idx         <= 3'b000;
      noise_control     <= 3'b000;
      noise_atten       <= 4'hF;
      tone2_freq        <= '0;
    end else begin
      bus.write_dropped <= bus.wr && !bus.ready;
      restart_noise     <= accept && idx == 3'b110 && (latch || RESTART_ON_DATA);
      if (accept && latch) latch_idx <= bus.data[6:4];
      if (accept && idx == 3'b100)
        tone2_freq <= latch ? {tone2_freq[COUNTER_BITS-1:4], bus.data[3:0]}
                            : COUNTER_BITS'({bus.data[5:0], tone2_freq[3:0]});
      if (accept && idx == 3'b110) noise_control <= bus.data[2:0];
      if (accept && idx == 3'b111) noise_atten <= bus.data[3:0];
    end
endmodule

// File: tb/tb_psg_noise_write_controller.sv
// tb_psg_noise_write_controller: random + directed check of two configurations against a behavioural model
module tb_psg_noise_write_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] data;
  int vectors = 0;
  int miscompares = 0;
  psg_noise_write_controller_if if0 ();
  psg_noise_write_controller_if if1 ();
  assign if0.wr = wr;
  assign if0.data = data;
  assign if1.wr = wr;
  assign if1.data = data;
  logic [2:0] nc0, nc1;
  logic [3:0] na0, na1;
  logic [9:0] tf0, tf1;
  logic       rn0, rn1;
  psg_noise_write_controller #(.WRITE_CYCLES(32), .COUNTER_BITS(10), .RESTART_ON_DATA(1'b1)) dut0 (
    .clk(clk), .reset_lfsr(rst), .bus(if0.slave),
    .noise_control(nc0), .noise_atten(na0), .tone2_freq(tf0), .restart_noise(rn0));
  psg_noise_write_controller #(.WRITE_CYCLES(0), .COUNTER_BITS(10), .RESTART_ON_DATA(1'b0)) dut1 (
    .clk(clk), .reset_lfsr(rst), .bus(if1.slave),
    .noise_control(nc1), .noise_atten(na1), .tone2_freq(tf1), .restart_noise(rn1));
  always #5 clk = ~clk;
  // behavioural model: ready is "edge number has reached free_at"
  int n = 0;
  int free_at[2] = '{0, 0};
  int lch[2] = '{0, 0};
  int lty[2] = '{0, 0};
  int tone[2] = '{0, 0};
  int mnc[2] = '{0, 0};
  int mna[2] = '{15, 15};
  bit mdrop[2] = '{0, 0};
  bit mrst[2] = '{0, 0};
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        free_at[i] = 0; lch[i] = 0; lty[i] = 0; tone[i] = 0;
        mnc[i] = 0; mna[i] = 15; mdrop[i] = 0; mrst[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int ch, ty, wc;
        bit lat, acc;
        wc = i == 0 ? 32 : 0;
        acc = wr && n >= free_at[i];
        mdrop[i] = wr && !acc;
        mrst[i] = 0;
        if (acc) begin
          free_at[i] = n + wc + 1;
          lat = data[7];
          if (lat) begin
            lch[i] = int'(data[6:5]);
            lty[i] = int'(data[4]);
          end
          ch = lch[i];
          ty = lty[i];
          if (ch == 2 && ty == 0)
            tone[i] = lat ? (tone[i] / 16) * 16 + int'(data[3:0]) : int'(data[5:0]) * 16 + tone[i] % 16;
          if (ch == 3 && ty == 0) begin
            mnc[i] = int'(data[2:0]);
            mrst[i] = lat || i == 0;
          end
          if (ch == 3 && ty == 1) mna[i] = int'(data[3:0]);
        end
      end
      n++;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    chk("ready0", int'(if0.ready), int'(n >= free_at[0]));
    chk("ready1", int'(if1.ready), int'(n >= free_at[1]));
    chk("drop0", int'(if0.write_dropped), int'(mdrop[0]));
    chk("drop1", int'(if1.write_dropped), int'(mdrop[1]));
    chk("restart0", int'(rn0), int'(mrst[0]));
    chk("restart1", int'(rn1), int'(mrst[1]));
    chk("ctrl0", int'(nc0), mnc[0]);
    chk("ctrl1", int'(nc1), mnc[1]);
    chk("atten0", int'(na0), mna[0]);
    chk("atten1", int'(na1), mna[1]);
    chk("tone0", int'(tf0), tone[0]);
    chk("tone1", int'(tf1), tone[1]);
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_ready0();
    int c = 0;
    while (!if0.ready && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) chk("ready_timeout", 0, 1);
  endtask
  task automatic write_byte(input logic [7:0] d);
    wait_ready0();
    wr = 1'b1;
    data = d;
    tick();
    wr = 1'b0;
  endtask
  initial begin
    int c;
    rst = 1'b1;
    wr = 1'b0;
    data = 8'h00;
    tick();
    tick();
    chk("lit_reset_ready", int'(if0.ready), 1);
    chk("lit_reset_atten", int'(na0), 15);
    rst = 1'b0;
    tick();
    write_byte(8'hE5);
    chk("lit_e5_ctrl", int'(nc0), 5);
    chk("lit_e5_restart", int'(rn0), 1);
    c = 0;
    while (!if0.ready && c < 100) begin
      c++;
      tick();
    end
    chk("lit_busy_len", c, 32);
    write_byte(8'hCA);
    chk("lit_ca_restart", int'(rn0), 0);
    write_byte(8'h3F);
    chk("lit_3f_restart", int'(rn0), 0);
    chk("lit_tone", int'(tf0), 10'h3FA);
    write_byte(8'hE3);
    chk("lit_e3_restart1", int'(rn1), 1);
    write_byte(8'h06);
    chk("lit_06_ctrl", int'(nc0), 6);
    chk("lit_06_restart0", int'(rn0), 1);
    chk("lit_06_restart1", int'(rn1), 0);
    wait_ready0();
    wr = 1'b1;
    data = 8'hF7;
    tick();
    chk("lit_f7_atten", int'(na0), 7);
    c = 0;
    for (int j = 1; j <= 32; j++) begin
      tick();
      c += int'(if0.write_dropped);
    end
    chk("lit_drop_count", c, 32);
    tick();
    chk("lit_reaccept_drop", int'(if0.write_dropped), 0);
    chk("lit_reaccept_busy", int'(if0.ready), 0);
    for (int j = 0; j < 6; j++) tick();
    wr = 1'b0;
    wait_ready0();
    wr = 1'b1;
    data = 8'hE4;
    tick();
    chk("lit_e4_restart1", int'(rn1), 1);
    data = 8'hE1;
    tick();
    chk("lit_e1_restart1", int'(rn1), 1);
    chk("lit_e1_ctrl1", int'(nc1), 1);
    wr = 1'b0;
    tick();
    chk("lit_after_restart1", int'(rn1), 0);
    write_byte(8'hE2);
    #1 rst = 1'b1;
    #1;
    chk("lit_async_ready", int'(if0.ready), 1);
    chk("lit_async_restart", int'(rn0), 0);
    chk("lit_async_ctrl", int'(nc0), 0);
    chk("lit_async_atten", int'(na0), 15);
    tick();
    wr = 1'b1;
    data = 8'hE6;
    rst = 1'b0;
    tick();
    chk("lit_release_ctrl", int'(nc0), 6);
    chk("lit_release_restart", int'(rn0), 1);
    wr = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(1, 0) == 1) d[6] = 1'b1;
      wr = $urandom_range(1, 0) == 1;
      data = d;
      rst = $urandom_range(399, 0) == 0;
      tick();
    end
    rst = 1'b0;
    wr = 1'b0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/psg_noise_write_controller.md
# psg_noise_write_controller

Bus-facing register-write sequencer for the SN76489 noise channel. It accepts the chip's byte-wide latch/data write protocol and enforces the chip's write-busy window through a ready handshake. It maintains the noise-control, noise-attenuation and channel-2 tone registers, and issues a one-cycle `restart_noise` strobe to the noise generator whenever the noise-control register is written. It sits between the host write port and the noise generator and its control decoder.

## Interface
- `WRITE_CYCLES`, default 32: number of cycles `ready` stays low after each accepted write. 0 means always ready.
- `COUNTER_BITS`, default 10: width of the tone frequency register.
- `RESTART_ON_DATA`, default 1: when 1, a data byte to the noise register also restarts the LFSR.
- Reset and clock (already decided): reset `reset_lfsr`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  clock.
- `reset_lfsr`  in  1  async active-high reset.
- `wr`  in  1  write strobe, sampled on the rising edge of `clk`.
- `data`  in  8  write byte.
- `ready`  out  1  high when a write will be accepted.
- `write_dropped`  out  1  one-cycle pulse when `wr` is high while `ready` is low.
- `noise_control`  out  3  {FB, NF1:NF0}, feeds the noise generator.
- `noise_atten`  out  4  noise channel attenuation; 4'hF means silent.
- `tone2_freq`  out  COUNTER_BITS  channel-2 tone period; used by noise mode 2'b11.
- `restart_noise`  out  1  one-cycle LFSR restart strobe.

## Operation
- Acceptance: a write is accepted on a rising edge where `wr && ready`. Otherwise, `wr` high raises `write_dropped` on the next cycle and changes no state.
- Latch byte (`data[7]=1`):
  - `data[6:5]` is the channel, `data[4]` is the type (0 = tone/noise control, 1 = attenuation), `data[3:0]` is the payload.
  - The 3-bit latch index {channel, type} is stored.
- Latch byte payload actions:
  - {2,0}: `tone2_freq[3:0]` ← `data[3:0]`.
  - {3,0}: `noise_control` ← `data[2:0]`, and `restart_noise` pulses.
  - {3,1}: `noise_atten` ← `data[3:0]`.
  - Any other index: the latch index is updated and the payload is discarded.
- Data byte (`data[7]=0`), acting on the stored latch index:
  - {2,0}: `tone2_freq[9:4]` ← `data[5:0]`. Upper bits are zero-extended if COUNTER_BITS>10.
  - {3,0}: `noise_control` ← `data[2:0]`. `restart_noise` pulses if RESTART_ON_DATA=1.
  - {3,1}: `noise_atten` ← `data[3:0]`.
  - Any other index: ignored. The latch index is unchanged.
- A `tone2_freq` write never restarts the LFSR, even when `noise_control[1:0]=2'b11`.
- Busy counter:
  - width = clog2(WRITE_CYCLES+1).
  - Loaded with WRITE_CYCLES on acceptance and decremented each cycle while nonzero.
  - `ready = (count==0)`, decoded from a register.
- States: IDLE (count=0, ready=1) and BUSY (count>0).
  - IDLE→BUSY on acceptance when WRITE_CYCLES>0.
  - BUSY→IDLE when the count reaches 0.

## Timing
- Reset values (async, immediate):
  - `ready`=1, `write_dropped`=0, `restart_noise`=0.
  - `noise_control`=3'b000, `noise_atten`=4'hF, `tone2_freq`=0.
  - latch index={0,0}, count=0.
- Register updates and `restart_noise` appear 1 cycle after the accepting edge, in the same cycle as each other. `restart_noise` is high for exactly 1 cycle.
- Ready window: accepting edge k → `ready` is low for cycles k+1 … k+WRITE_CYCLES and high again at k+WRITE_CYCLES+1.
- Back-to-back writes:
  - WRITE_CYCLES=0: back-to-back accepts every cycle, with one restart pulse per noise write.
  - Consecutive noise writes produce consecutive restart pulses.
- `wr` held high across a busy window: the first edge is accepted, every busy edge pulses `write_dropped`, and the first edge with `ready`=1 is accepted again. The byte used is the one present on `data` at that edge.
- Reset mid-busy: count clears and `ready`=1 immediately. A `restart_noise` pulse in flight is cleared. Reset deasserting with `wr` high accepts on the first edge after release.

## Test plan
- Reset: assert `reset_lfsr` mid-busy → `ready`=1, `noise_atten`=F, `noise_control`=0, `restart_noise`=0 with no clock edge needed.
- Write 8'hE5 (latch {3,0}, payload 5) → `noise_control`=3'b101 and a single `restart_noise` pulse 1 cycle later. `ready` is low for exactly 32 cycles.
- Write 8'hCA, wait for ready, write 8'h3F → `tone2_freq`=10'h3FA with no `restart_noise` at either write.
- Write 8'hE3 then data 8'h06, with RESTART_ON_DATA=1 → `noise_control`=3'b110 and two restart pulses. Repeat with RESTART_ON_DATA=0 → one pulse.
- Hold `wr` high for 40 cycles with `data`=8'hF7 → one accept at cycle 0, 32 `write_dropped` pulses, re-accept at cycle 33, `noise_atten`=4'h7.
- WRITE_CYCLES=0: write 8'hE4, 8'hE1 on consecutive cycles → `restart_noise` high for 2 consecutive cycles, final `noise_control`=3'b001.
